sram_rr_arb: RTL

//  Round-robin arbiter that shares one single-port SRAM macro between N requesters.

---
 rtl/sram_rr_arb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sram_rr_arb.sv
// Round-robin arbiter sharing one single-port SRAM macro between NUM_REQ requesters.
// Optional burst lock is enabled by defining SRAM_ARB_LOCK_EN.
module sram_rr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0]              we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
`ifdef SRAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]              lock_i,
`endif
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            sram_en_o,
    output logic                            sram_we_o,
    output logic [ADDR_WIDTH-1:0]           sram_addr_o,
    output logic [DATA_WIDTH-1:0]           sram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]         sram_be_o,
    input  logic [DATA_WIDTH-1:0]           sram_rdata_i
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = DATA_WIDTH / 8;

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [PW-1:0]      sel;
    logic               found;
    logic               gnt_vld;
    logic [PW-1:0]      sel_next;
    int                 cand;

    // Scan requests starting at the pointer, wrapping past the top index.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_i[cand]) begin
                found = 1'b1;
                sel   = PW'(cand);
            end
        end
    end

    assign gnt_vld  = found && rst_n_i;
    assign sel_next = (int'(sel) == NUM_REQ - 1) ? '0 : PW'(int'(sel) + 1);

    always_comb begin
        gnt_o        = '0;
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (gnt_vld) begin
            gnt_o[sel]   = 1'b1;
            sram_en_o    = 1'b1;
            sram_we_o    = we_i[sel];
            sram_addr_o  = addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
            sram_wdata_o = wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
            sram_be_o    = be_i[sel*BW +: BW];
        end
    end

    always_comb begin
        rvalid_d = '0;
        if (gnt_vld && !we_i[sel]) rvalid_d = gnt_o;
    end

`ifdef SRAM_ARB_LOCK_EN
    localparam int LW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    logic [LW-1:0] lock_cnt_q, lock_cnt_d;

    // A locked grant parks the pointer on its owner until MAX_LOCK grants force rotation.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = '0;
        if (gnt_vld) begin
            rr_ptr_d = sel_next;
            if (lock_i[sel]) begin
                if (lock_cnt_q == LW'(MAX_LOCK - 1)) begin
                    rr_ptr_d   = sel_next;
                    lock_cnt_d = '0;
                end else begin
                    rr_ptr_d   = sel;
                    lock_cnt_d = (rr_ptr_q == sel) ? lock_cnt_q + 1'b1 : LW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) lock_cnt_q <= '0;
        else          lock_cnt_q <= lock_cnt_d;
    end
`else
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) rr_ptr_d = sel_next;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rr_ptr_q <= '0;
            rvalid_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Read data comes straight from the macro; rvalid_o alone qualifies it.
    assign rvalid_o = rst_n_i ? rvalid_q : '0;
    assign rdata_o  = sram_rdata_i;

endmodule
